// File: rtl/eth_tx_framer.sv
// Ethernet transmit framer: adds preamble/SFD, pads short frames and appends an optional FCS,
// then holds an inter-frame gap. The FCS path is compiled in only when ETH_TX_FCS_EN is defined.
module eth_tx_framer #(
    parameter int unsigned IFG_CYCLES = 12,
    parameter int unsigned MIN_FRAME  = 60
) (
    input  logic       logic_clk,
    input  logic       logic_rst,
    input  logic [7:0] net_tdata_in,
    input  logic       net_tvalid_in,
    output logic       net_tready_out,
    input  logic       net_tlast_in,
    output logic [7:0] mac_tdata_out,
    output logic       mac_tvalid_out,
    input  logic       mac_tready_in,
    output logic       mac_tlast_out
);

    typedef enum logic [2:0] {
        StIdle,
        StPreamble,
        StData,
        StPad,
        StFcs,
        StIfg
    } state_e;

    localparam logic [10:0] MinFrame = 11'(MIN_FRAME);
    localparam logic [15:0] IfgLast  = (IFG_CYCLES > 0) ? 16'(IFG_CYCLES - 1) : 16'd0;

    state_e      state_q, state_d;
    state_e      end_state;
    state_e      body_done_state;
    logic [10:0] cnt_q, cnt_d, cnt_inc;
    logic [2:0]  idx_q, idx_d;
    logic [15:0] ifg_q, ifg_d;
    logic        out_hs;

`ifdef ETH_TX_FCS_EN
    logic [31:0] crc_q, crc_d;
    logic [31:0] crc_fcs;

    function automatic logic [31:0] crc_next(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    assign crc_fcs = ~crc_q;
`endif

    always_comb begin
        // Defaults: everything idle, state registers hold, gap counter parked at zero.
        state_d        = state_q;
        cnt_d          = cnt_q;
        idx_d          = idx_q;
        ifg_d          = '0;
        net_tready_out = 1'b0;
        mac_tdata_out  = 8'h00;
        mac_tvalid_out = 1'b0;
        mac_tlast_out  = 1'b0;
`ifdef ETH_TX_FCS_EN
        crc_d          = crc_q;
`endif

        cnt_inc   = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;
        end_state = (IFG_CYCLES != 0) ? StIfg : StIdle;
`ifdef ETH_TX_FCS_EN
        body_done_state = StFcs;
`else
        body_done_state = end_state;
`endif

        unique case (state_q)
            StIdle: begin
                if (net_tvalid_in) begin
                    state_d = StPreamble;
                    cnt_d   = '0;
                    idx_d   = '0;
`ifdef ETH_TX_FCS_EN
                    crc_d   = 32'hFFFF_FFFF;
`endif
                end
            end
            StPreamble: begin
                mac_tvalid_out = 1'b1;
                mac_tdata_out  = (idx_q == 3'd7) ? 8'hD5 : 8'h55;
            end
            StData: begin
                mac_tdata_out  = net_tdata_in;
                mac_tvalid_out = net_tvalid_in;
                net_tready_out = mac_tready_in;
`ifndef ETH_TX_FCS_EN
                mac_tlast_out  = net_tvalid_in && net_tlast_in && (cnt_inc >= MinFrame);
`endif
            end
            StPad: begin
                mac_tvalid_out = 1'b1;
`ifndef ETH_TX_FCS_EN
                mac_tlast_out  = (cnt_inc >= MinFrame);
`endif
            end
            StFcs: begin
`ifdef ETH_TX_FCS_EN
                mac_tvalid_out = 1'b1;
                mac_tdata_out  = crc_fcs[{idx_q[1:0], 3'b000} +: 8];
                mac_tlast_out  = (idx_q[1:0] == 2'd3);
`endif
            end
            StIfg: begin
                // A frame already waiting skips the IDLE cycle so the gap is exactly IFG_CYCLES.
                if (ifg_q == IfgLast) begin
                    if (net_tvalid_in) begin
                        state_d = StPreamble;
                        cnt_d   = '0;
                        idx_d   = '0;
`ifdef ETH_TX_FCS_EN
                        crc_d   = 32'hFFFF_FFFF;
`endif
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    ifg_d = ifg_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        out_hs = mac_tvalid_out && mac_tready_in;

        if (out_hs) begin
            unique case (state_q)
                StPreamble: begin
                    if (idx_q == 3'd7) begin
                        state_d = StData;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
                StData: begin
                    cnt_d = cnt_inc;
`ifdef ETH_TX_FCS_EN
                    crc_d = crc_next(crc_q, net_tdata_in);
`endif
                    if (net_tlast_in) begin
                        state_d = (cnt_inc < MinFrame) ? StPad : body_done_state;
                        idx_d   = '0;
                    end
                end
                StPad: begin
                    cnt_d = cnt_inc;
`ifdef ETH_TX_FCS_EN
                    crc_d = crc_next(crc_q, 8'h00);
`endif
                    if (cnt_inc >= MinFrame) begin
                        state_d = body_done_state;
                        idx_d   = '0;
                    end
                end
                StFcs: begin
                    if (idx_q[1:0] == 2'd3) begin
                        state_d = end_state;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge logic_clk) begin
        if (logic_rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            ifg_q   <= '0;
`ifdef ETH_TX_FCS_EN
            crc_q   <= 32'hFFFF_FFFF;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            ifg_q   <= ifg_d;
`ifdef ETH_TX_FCS_EN
            crc_q   <= crc_d;
`endif
        end
    end

endmodule

// File: tb/tb_eth_tx_framer.sv
// Directed bench for eth_tx_framer; expectations follow ETH_TX_FCS_EN when it is defined.
module tb_eth_tx_framer;

    localparam int unsigned IFG  = 12;
    localparam int unsigned MINF = 60;
`ifdef ETH_TX_FCS_EN
    localparam int FCS_LEN = 4;
`else
    localparam int FCS_LEN = 0;
`endif

    localparam logic [7:0] ARP [42] = '{
        8'hff, 8'hff, 8'hff, 8'hff, 8'hff, 8'hff, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55,
        8'h08, 8'h06, 8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h01,
        8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'hc0, 8'ha8, 8'h01, 8'h0a,
        8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hc0, 8'ha8, 8'h01, 8'h01
    };

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] net_tdata = 8'h00;
    logic       net_tvalid = 1'b0;
    logic       net_tready;
    logic       net_tlast = 1'b0;
    logic [7:0] mac_tdata;
    logic       mac_tvalid;
    logic       mac_tready = 1'b1;
    logic       mac_tlast;

    int checks = 0;
    int failures = 0;

    logic [7:0] pay[$];
    logic [7:0] exp_d[$];
    bit         exp_l[$];
    logic [7:0] cap_d[$];
    bit         cap_l[$];
    int         cap_c[$];
    int         cycle = 0;
    bit         rdy_rand = 1'b0;
    bit         abort = 1'b0;
    int         stall_errs = 0;
    bit         stalled = 1'b0;
    logic [7:0] stall_data = 8'h00;

    always #5 clk = ~clk;

    eth_tx_framer #(.IFG_CYCLES(IFG), .MIN_FRAME(MINF)) dut (
        .logic_clk     (clk),
        .logic_rst     (rst),
        .net_tdata_in  (net_tdata),
        .net_tvalid_in (net_tvalid),
        .net_tready_out(net_tready),
        .net_tlast_in  (net_tlast),
        .mac_tdata_out (mac_tdata),
        .mac_tvalid_out(mac_tvalid),
        .mac_tready_in (mac_tready),
        .mac_tlast_out (mac_tlast)
    );

    always @(posedge clk) begin
        #1;
        mac_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Output monitor: captures every handshake and tracks stall stability.
    always @(negedge clk) begin
        cycle++;
        if (stalled && (mac_tvalid !== 1'b1 || mac_tdata !== stall_data)) stall_errs++;
        stalled = mac_tvalid && !mac_tready && !rst;
        stall_data = mac_tdata;
        if (mac_tvalid && mac_tready && !rst) begin
            cap_d.push_back(mac_tdata);
            cap_l.push_back(mac_tlast);
            cap_c.push_back(cycle);
        end
    end

    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc ^ {24'd0, b};
        for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    function automatic int count_last();
        int n = 0;
        foreach (cap_l[i]) if (cap_l[i]) n++;
        return n;
    endfunction

    function automatic int frame_diffs();
        int d = 0;
        if (cap_d.size() != exp_d.size()) d++;
        for (int i = 0; i < cap_d.size() && i < exp_d.size(); i++)
            if (cap_d[i] !== exp_d[i] || cap_l[i] !== exp_l[i]) d++;
        return d;
    endfunction

    task automatic clear_all();
        cap_d.delete(); cap_l.delete(); cap_c.delete();
        exp_d.delete(); exp_l.delete();
    endtask

    task automatic set_payload(input int len, input int seed);
        pay.delete();
        for (int i = 0; i < len; i++) pay.push_back(8'(i * 7 + seed));
    endtask

    task automatic set_arp();
        pay.delete();
        for (int i = 0; i < 42; i++) pay.push_back(ARP[i]);
    endtask

    // Appends the expected framed output of the current payload.
    task automatic build_expected();
        int n;
        logic [31:0] crc;
        for (int i = 0; i < 7; i++) begin exp_d.push_back(8'h55); exp_l.push_back(1'b0); end
        exp_d.push_back(8'hD5); exp_l.push_back(1'b0);
        crc = 32'hFFFFFFFF;
        n = 0;
        for (int i = 0; i < pay.size(); i++) begin
            exp_d.push_back(pay[i]); exp_l.push_back(1'b0);
            crc = crc_byte(crc, pay[i]);
            n++;
        end
        while (n < MINF) begin
            exp_d.push_back(8'h00); exp_l.push_back(1'b0);
            crc = crc_byte(crc, 8'h00);
            n++;
        end
`ifdef ETH_TX_FCS_EN
        for (int k = 0; k < 4; k++) begin
            exp_d.push_back(8'(~(crc >> (8 * k)))); exp_l.push_back(1'b0);
        end
`endif
        exp_l[exp_l.size() - 1] = 1'b1;
    endtask

    task automatic send_frame();
        int t;
        bit acc;
        for (int i = 0; i < pay.size() && !abort; i++) begin
            net_tdata = pay[i];
            net_tvalid = 1'b1;
            net_tlast = (i == pay.size() - 1);
            t = 0;
            acc = 1'b0;
            while (!acc && !abort && t < 3000) begin
                @(negedge clk);
                acc = net_tready;
                t++;
            end
            if (!acc && !abort) begin
                checks++; failures++;
                $display("FAIL source_timeout: byte %0d not accepted, got tready=%b required 1", i,
                         net_tready);
                abort = 1'b1;
            end
            if (!abort) begin @(posedge clk); #1; end
        end
        net_tvalid = 1'b0;
        net_tlast = 1'b0;
        net_tdata = 8'h00;
    endtask

    task automatic wait_last(input int n, input string name);
        int t = 0;
        while (count_last() < n && t < 4000) begin @(posedge clk); t++; end
        checks++;
        if (count_last() < n) begin
            failures++;
            $display("FAIL %s_timeout: tlast count %0d required %0d", name, count_last(), n);
        end
        repeat (IFG + 4) @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input string name, input int exp_len);
        int d;
        clear_all();
        build_expected();
        abort = 1'b0;
        send_frame();
        wait_last(1, name);
        checks++;
        if (cap_d.size() !== exp_len) begin
            failures++;
            $display("FAIL %s_len: got %0d bytes required %0d", name, cap_d.size(), exp_len);
        end
        d = frame_diffs();
        checks++;
        if (d !== 0) begin
            failures++;
            $display("FAIL %s_bytes: got %0d differing bytes required 0", name, d);
        end
    endtask

    task automatic test_reset();
        net_tvalid = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks += 4;
        if (mac_tvalid !== 1'b0) begin failures++; $display("FAIL rst_tvalid: got %b required 0", mac_tvalid); end
        if (mac_tdata !== 8'h00) begin failures++; $display("FAIL rst_tdata: got %h required 00", mac_tdata); end
        if (mac_tlast !== 1'b0) begin failures++; $display("FAIL rst_tlast: got %b required 0", mac_tlast); end
        if (net_tready !== 1'b0) begin failures++; $display("FAIL rst_tready: got %b required 0", net_tready); end
        net_tvalid = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks += 3;
        if (mac_tvalid !== 1'b0) begin failures++; $display("FAIL idle_tvalid: got %b required 0", mac_tvalid); end
        if (mac_tdata !== 8'h00) begin failures++; $display("FAIL idle_tdata: got %h required 00", mac_tdata); end
        if (net_tready !== 1'b0) begin failures++; $display("FAIL idle_tready: got %b required 0", net_tready); end
    endtask

    task automatic test_arp();
        logic [31:0] crc;
        set_arp();
        run_frame("arp", 68 + FCS_LEN);
`ifdef ETH_TX_FCS_EN
        crc = 32'hFFFFFFFF;
        for (int i = 8; i < cap_d.size(); i++) crc = crc_byte(crc, cap_d[i]);
        checks++;
        if (crc !== 32'hDEBB20E3) begin
            failures++;
            $display("FAIL arp_residue: got %h required debb20e3", crc);
        end
`else
        crc = 32'h0;
`endif
    endtask

    task automatic test_long();
        set_payload(100, 3);
        run_frame("long100", 108 + FCS_LEN);
    endtask

    task automatic test_min_boundary();
        set_payload(1, 9);
        run_frame("one_byte", 68 + FCS_LEN);
        set_payload(59, 17);
        run_frame("len59", 68 + FCS_LEN);
        set_payload(60, 29);
        run_frame("len60", 68 + FCS_LEN);
    endtask

    task automatic test_stall();
        stall_errs = 0;
        rdy_rand = 1'b1;
        set_arp();
        run_frame("stall", 68 + FCS_LEN);
        rdy_rand = 1'b0;
        checks++;
        if (stall_errs !== 0) begin
            failures++;
            $display("FAIL stall_stable: got %0d unstable stalls required 0", stall_errs);
        end
    endtask

    task automatic test_back_to_back();
        int d;
        int first_len;
        clear_all();
        abort = 1'b0;
        set_payload(20, 5);
        build_expected();
        first_len = exp_d.size();
        send_frame();
        set_payload(70, 41);
        build_expected();
        send_frame();
        wait_last(2, "b2b");
        checks++;
        if (cap_d.size() !== 2 * (68 + FCS_LEN) + 10) begin
            failures++;
            $display("FAIL b2b_len: got %0d bytes required %0d", cap_d.size(), 2 * (68 + FCS_LEN) + 10);
        end
        d = frame_diffs();
        checks++;
        if (d !== 0) begin failures++; $display("FAIL b2b_bytes: got %0d differing bytes required 0", d); end
        checks++;
        if (cap_c.size() > first_len && (cap_c[first_len] - cap_c[first_len - 1] - 1) !== IFG) begin
            failures++;
            $display("FAIL b2b_gap: got %0d idle cycles required %0d",
                     cap_c[first_len] - cap_c[first_len - 1] - 1, IFG);
        end else if (cap_c.size() <= first_len) begin
            failures++;
            $display("FAIL b2b_gap: got %0d bytes required more than %0d", cap_c.size(), first_len);
        end
    endtask

    task automatic test_reset_mid();
        int t = 0;
        clear_all();
        abort = 1'b0;
        set_payload(60, 77);
        fork
            send_frame();
            begin
                while (cap_d.size() < 30 && t < 2000) begin @(posedge clk); #2; t++; end
                abort = 1'b1;
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
            end
        join
        #1;
        checks += 5;
        if (mac_tvalid !== 1'b0) begin failures++; $display("FAIL mid_rst_tvalid: got %b required 0", mac_tvalid); end
        if (mac_tdata !== 8'h00) begin failures++; $display("FAIL mid_rst_tdata: got %h required 00", mac_tdata); end
        if (mac_tlast !== 1'b0) begin failures++; $display("FAIL mid_rst_tlast: got %b required 0", mac_tlast); end
        if (net_tready !== 1'b0) begin failures++; $display("FAIL mid_rst_tready: got %b required 0", net_tready); end
        if (count_last() !== 0 || cap_d.size() < 30) begin
            failures++;
            $display("FAIL mid_rst_abandon: got tlast=%0d bytes=%0d required 0 and >=30",
                     count_last(), cap_d.size());
        end
        repeat (3) @(posedge clk);
        #1;
        set_payload(60, 101);
        run_frame("after_rst", 68 + FCS_LEN);
    endtask

    initial begin
        test_reset();
        test_arp();
        test_long();
        test_min_boundary();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
